// File: rtl/eth_frame_arbiter_if.sv
// Word-stream bundle used by eth_frame_arbiter: valid/ready handshake,
// one data word and an end-of-frame flag.
// master drives valid/data/last and receives ready; slave is the mirror.
interface eth_frame_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/eth_frame_arbiter.sv
// eth_frame_arbiter: frame-granular round-robin arbiter sharing one egress
// word stream between ingress ports A and B. A grant lasts a whole frame.
// The datapath is a combinational pass-through and adds no registers.
// Per-port delivered-frame counters wrap at 2^CNT_W.
// Optional feature macro: ETH_ARB_FRAME_LIMIT_EN. When it is defined, frames
// longer than MAX_WORDS are cut at MAX_WORDS words and err_oversize is raised.
// The rest of the oversize frame is then drained and discarded.
module eth_frame_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 380,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  eth_frame_arbiter_if.slave   a_if,
  eth_frame_arbiter_if.slave   b_if,
  eth_frame_arbiter_if.master  out_if,
  output logic                 out_src,
  output logic                 err_oversize,
  output logic [CNT_W-1:0]     frames_a,
  output logic [CNT_W-1:0]     frames_b
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT_A = 3'd1,
    S_GRANT_B = 3'd2,
    S_DROP_A  = 3'd3,
    S_DROP_B  = 3'd4
  } state_t;

  // MAX_WORDS must be representable by the CNT_W-bit word counter.
  // This block exists only when the parameter combination is unusable.
  if (MAX_WORDS < 1 || MAX_WORDS > 2**CNT_W) begin : g_max_words_out_of_range
  end

  state_t           state_q, state_d;
  logic             prio_q, prio_d;   // 0 = A wins a tie, 1 = B wins a tie
  logic             src_q, src_d;     // port owning the current or last grant
  logic [CNT_W-1:0] frames_a_q, frames_a_d;
  logic [CNT_W-1:0] frames_b_q, frames_b_d;

`ifdef ETH_ARB_FRAME_LIMIT_EN
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
`endif

  // Ingress signals of the currently granted port. src_q tracks GRANT_x/DROP_x.
  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic              frame_done;

  assign cur_valid = src_q ? b_if.valid : a_if.valid;
  assign cur_last  = src_q ? b_if.last  : a_if.last;
  assign cur_data  = src_q ? b_if.data  : a_if.data;

  // Next-state, handshake and egress steering, with all outputs defaulted first.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    src_d        = src_q;
    frames_a_d   = frames_a_q;
    frames_b_d   = frames_b_q;
    frame_done   = 1'b0;
    a_if.ready   = 1'b0;
    b_if.ready   = 1'b0;
    out_if.valid = 1'b0;
    out_if.data  = '0;
    out_if.last  = 1'b0;
    err_oversize = 1'b0;
`ifdef ETH_ARB_FRAME_LIMIT_EN
    word_cnt_d   = word_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef ETH_ARB_FRAME_LIMIT_EN
        word_cnt_d = '0;
`endif
        if (a_if.valid && (!b_if.valid || !prio_q)) begin
          state_d = S_GRANT_A;
          src_d   = 1'b0;
        end else if (b_if.valid) begin
          state_d = S_GRANT_B;
          src_d   = 1'b1;
        end
      end

      S_GRANT_A, S_GRANT_B: begin
        out_if.valid = cur_valid;
        out_if.data  = cur_data;
        out_if.last  = cur_last;
        if (src_q) b_if.ready = out_if.ready;
        else       a_if.ready = out_if.ready;

        if (cur_valid && out_if.ready) begin
`ifdef ETH_ARB_FRAME_LIMIT_EN
          word_cnt_d = word_cnt_q + 1'b1;
`endif
          if (cur_last) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
`ifdef ETH_ARB_FRAME_LIMIT_EN
          else if (word_cnt_q == LAST_IDX) begin
            // Cut the frame here: close it on egress and swallow the tail.
            out_if.last  = 1'b1;
            err_oversize = 1'b1;
            frame_done   = 1'b1;
            state_d      = src_q ? S_DROP_B : S_DROP_A;
          end
`endif
        end
      end

`ifdef ETH_ARB_FRAME_LIMIT_EN
      S_DROP_A, S_DROP_B: begin
        if (src_q) b_if.ready = 1'b1;
        else       a_if.ready = 1'b1;
        if (cur_valid && cur_last) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // A delivered frame (complete or truncated) counts and hands the tie to the other port.
    if (frame_done) begin
      prio_d = ~src_q;
      if (src_q) frames_b_d = frames_b_q + 1'b1;
      else       frames_a_d = frames_a_q + 1'b1;
    end
  end

  // State, priority, grant source and counters; synchronous reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      src_q      <= 1'b0;
      frames_a_q <= '0;
      frames_b_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      src_q      <= src_d;
      frames_a_q <= frames_a_d;
      frames_b_q <= frames_b_d;
    end
  end

`ifdef ETH_ARB_FRAME_LIMIT_EN
  // Beat counter for the current grant, used to detect oversize frames.
  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end
`endif

  assign out_src  = src_q;
  assign frames_a = frames_a_q;
  assign frames_b = frames_b_q;

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Directed bench for eth_frame_arbiter, with hand-computed expectations.
// The optional oversize section is built only when ETH_ARB_FRAME_LIMIT_EN is defined.
module tb_eth_frame_arbiter;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 8;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_frame_arbiter_if #(.DATA_W(DATA_W)) a_if ();
  eth_frame_arbiter_if #(.DATA_W(DATA_W)) b_if ();
  eth_frame_arbiter_if #(.DATA_W(DATA_W)) out_if ();

  logic             out_src;
  logic             err_oversize;
  logic [CNT_W-1:0] frames_a;
  logic [CNT_W-1:0] frames_b;

  int checks   = 0;
  int failures = 0;

  eth_frame_arbiter #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_if         (a_if),
    .b_if         (b_if),
    .out_if       (out_if),
    .out_src      (out_src),
    .err_oversize (err_oversize),
    .frames_a     (frames_a),
    .frames_b     (frames_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit port, input logic v, input logic [31:0] d, input logic l);
    if (port) begin
      b_if.valid = v; b_if.data = d; b_if.last = l;
    end else begin
      a_if.valid = v; a_if.data = d; a_if.last = l;
    end
  endtask

  // One idle (arbitration) cycle, then n words with out_ready held at 1.
  task automatic run_frame(input bit port, input int n, input logic [31:0] base, input string tag);
    set_port(port, 1'b1, base, n == 1);
    to_neg();
    check_eq({tag, "_idle_valid"}, out_if.valid, 32'd0);
    to_pos();
    for (int i = 0; i < n; i++) begin
      set_port(port, 1'b1, base + i, i == n - 1);
      to_neg();
      check_eq({tag, "_valid"}, out_if.valid, 32'd1);
      check_eq({tag, "_data"},  out_if.data, base + i);
      check_eq({tag, "_last"},  out_if.last, (i == n - 1) ? 32'd1 : 32'd0);
      check_eq({tag, "_src"},   out_src, {31'd0, port});
      check_eq({tag, "_rdy"},   port ? b_if.ready : a_if.ready, 32'd1);
      check_eq({tag, "_other_rdy"}, port ? a_if.ready : b_if.ready, 32'd0);
      check_eq({tag, "_err"},   err_oversize, 32'd0);
      to_pos();
    end
    set_port(port, 1'b0, 32'd0, 1'b0);
    $display("frame %s port=%0d words=%0d", tag, port, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k;
    rst = 1'b1;
    set_port(1'b0, 1'b0, 32'd0, 1'b0);
    set_port(1'b1, 1'b0, 32'd0, 1'b0);
    out_if.ready = 1'b0;

    // Reset state
    to_pos();
    to_neg();
    check_eq("rst_out_valid", out_if.valid, 32'd0);
    check_eq("rst_a_ready",   a_if.ready, 32'd0);
    check_eq("rst_b_ready",   b_if.ready, 32'd0);
    check_eq("rst_out_last",  out_if.last, 32'd0);
    check_eq("rst_err",       err_oversize, 32'd0);
    check_eq("rst_out_src",   out_src, 32'd0);
    check_eq("rst_frames_a",  frames_a, 32'd0);
    check_eq("rst_frames_b",  frames_b, 32'd0);
    to_pos();
    rst = 1'b0;

    // Test 1: 4-word frame on A only
    out_if.ready = 1'b1;
    run_frame(1'b0, 4, 32'hA000_0000, "t1");
    to_neg();
    check_eq("t1_frames_a", frames_a, 32'd1);
    check_eq("t1_out_src",  out_src, 32'd0);
    check_eq("t1_end_valid", out_if.valid, 32'd0);
    to_pos();

    // Test 2: simultaneous requests after reset; A, idle, B, then A again
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    set_port(1'b1, 1'b1, 32'hB100_0000, 1'b0);
    run_frame(1'b0, 3, 32'hA100_0000, "t2_a1");
    run_frame(1'b1, 3, 32'hB100_0000, "t2_b1");
    set_port(1'b1, 1'b1, 32'hB200_0000, 1'b0);
    run_frame(1'b0, 3, 32'hA200_0000, "t2_a2");
    run_frame(1'b1, 3, 32'hB200_0000, "t2_b2");
    to_neg();
    check_eq("t2_frames_a", frames_a, 32'd2);
    check_eq("t2_frames_b", frames_b, 32'd2);
    to_pos();

    // Test 3: 5-word frame on B with egress backpressure 1,0,1,0,...
    set_port(1'b1, 1'b1, 32'hB300_0000, 1'b0);
    to_neg();
    check_eq("t3_idle_valid", out_if.valid, 32'd0);
    to_pos();
    set_port(1'b0, 1'b1, 32'hA300_0000, 1'b0);
    idx = 0;
    k = 0;
    while (idx < 5 && k < 20) begin
      out_if.ready = (k % 2 == 0);
      set_port(1'b1, 1'b1, 32'hB300_0000 + idx, idx == 4);
      to_neg();
      check_eq("t3_b_ready", b_if.ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("t3_a_ready", a_if.ready, 32'd0);
      check_eq("t3_valid",   out_if.valid, 32'd1);
      check_eq("t3_data",    out_if.data, 32'hB300_0000 + idx);
      check_eq("t3_last",    out_if.last, (idx == 4) ? 32'd1 : 32'd0);
      check_eq("t3_src",     out_src, 32'd1);
      to_pos();
      if (k % 2 == 0) idx++;
      k++;
    end
    check_eq("t3_words_done", idx, 32'd5);
    set_port(1'b0, 1'b0, 32'd0, 1'b0);
    set_port(1'b1, 1'b0, 32'd0, 1'b0);
    out_if.ready = 1'b1;
    to_neg();
    check_eq("t3_frames_b", frames_b, 32'd3);
    check_eq("t3_end_valid", out_if.valid, 32'd0);
    to_pos();
    $display("frame t3 port=1 words=5 cycles=%0d", k);

    // Test 4: reset during word 2 of a 6-word A frame
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    set_port(1'b0, 1'b1, 32'hA400_0000, 1'b0);
    to_neg();
    check_eq("t4_idle_valid", out_if.valid, 32'd0);
    to_pos();
    to_neg();
    check_eq("t4_w1_data", out_if.data, 32'hA400_0000);
    to_pos();
    set_port(1'b0, 1'b1, 32'hA400_0001, 1'b0);
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    set_port(1'b0, 1'b1, 32'hA400_0002, 1'b0);
    to_neg();
    check_eq("t4_valid",    out_if.valid, 32'd0);
    check_eq("t4_a_ready",  a_if.ready, 32'd0);
    check_eq("t4_last",     out_if.last, 32'd0);
    check_eq("t4_data",     out_if.data, 32'd0);
    check_eq("t4_frames_a", frames_a, 32'd0);
    check_eq("t4_out_src",  out_src, 32'd0);
    set_port(1'b0, 1'b0, 32'd0, 1'b0);
    to_pos();
    $display("frame t4 port=0 aborted by reset");

    // Test 5: 17 single-word frames on A wrap the 4-bit counter to 1
    for (int f = 0; f < 17; f++) begin
      run_frame(1'b0, 1, 32'hC000_0000 + f, "t5");
    end
    to_neg();
    check_eq("t5_frames_a", frames_a, 32'd1);
    check_eq("t5_frames_b", frames_b, 32'd0);
    to_pos();

`ifdef ETH_ARB_FRAME_LIMIT_EN
    // Test 6: 12-word frame truncated at 8, then an exact 8-word frame
    set_port(1'b0, 1'b1, 32'hD000_0000, 1'b0);
    to_neg();
    check_eq("t6_idle_valid", out_if.valid, 32'd0);
    to_pos();
    for (int i = 0; i < 12; i++) begin
      set_port(1'b0, 1'b1, 32'hD000_0000 + i, i == 11);
      to_neg();
      check_eq("t6_a_ready", a_if.ready, 32'd1);
      if (i < 8) begin
        check_eq("t6_valid", out_if.valid, 32'd1);
        check_eq("t6_data",  out_if.data, 32'hD000_0000 + i);
        check_eq("t6_last",  out_if.last, (i == 7) ? 32'd1 : 32'd0);
        check_eq("t6_err",   err_oversize, (i == 7) ? 32'd1 : 32'd0);
      end else begin
        check_eq("t6_drop_valid", out_if.valid, 32'd0);
        check_eq("t6_drop_err",   err_oversize, 32'd0);
      end
      to_pos();
    end
    set_port(1'b0, 1'b0, 32'd0, 1'b0);
    to_neg();
    check_eq("t6_frames_a",  frames_a, 32'd2);
    check_eq("t6_end_valid", out_if.valid, 32'd0);
    check_eq("t6_end_ready", a_if.ready, 32'd0);
    to_pos();
    $display("frame t6 port=0 words=12 truncated to 8");
    run_frame(1'b0, 8, 32'hD100_0000, "t6_exact");
    to_neg();
    check_eq("t6_exact_frames_a", frames_a, 32'd3);
    to_pos();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_frame_arbiter.md
# eth_frame_arbiter

Frame-granular round-robin arbiter that shares the single 32-bit egress datapath of the Ethernet switch between ingress ports A and B. Each port presents a valid/ready word stream delimited by a last flag. The arbiter grants one port for a whole frame and forwards that frame unmodified. It also keeps per-port delivered-frame counters.

## Interface
- DATA_W, 32, word width of all data buses
- MAX_WORDS, 380, maximum words per frame (1518 B / 4, rounded up); used only with the frame-limit feature
- CNT_W, 16, width of the frame counters and the word counter
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  port A word valid
- a_data  in  DATA_W  port A word
- a_last  in  1  final word of the port A frame
- a_ready  out  1  port A word accepted this cycle
- b_valid, b_data, b_last, b_ready: same as port A, for port B
- out_valid  out  1  egress word valid
- out_data  out  DATA_W  egress word
- out_last  out  1  final egress word of the frame
- out_ready  in  1  egress sink accepts the word
- out_src  out  1  granted port: 0 = A, 1 = B
- err_oversize  out  1  one-cycle pulse when a frame is truncated
- frames_a, frames_b  out  CNT_W  frames delivered per port; wrap at 2^CNT_W

## Operation
- States: IDLE, GRANT_A, GRANT_B, plus DROP_A and DROP_B (frame-limit feature only).
- Priority pointer `prio` (0 = A) is a register.
- **IDLE**
  - a_ready = b_ready = out_valid = 0.
  - If only one port is valid, move to that port's GRANT state.
  - If both are valid, move to GRANT of the port selected by `prio`.
  - If neither is valid, stay in IDLE.
- **GRANT_x** (combinational pass-through)
  - out_valid = x_valid, out_data = x_data, out_last = x_last, x_ready = out_ready.
  - The other port's ready = 0.
  - out_src = x.
- **Beat and frame completion**
  - A beat is x_valid & out_ready.
  - A beat with x_last completes the frame: frames_x increments, `prio` is set to the other port, next state is IDLE.
- out_data is don't-care when out_valid = 0 and is driven as 0.
- out_src holds its last grant value while in IDLE.
- A granted port that drops valid mid-frame keeps the grant indefinitely. There is no timeout.

## Timing
- Reset values:
  - state = IDLE, prio = 0, out_src = 0, frames_a = frames_b = 0.
  - Word counter = 0.
  - Hence out_valid, a_ready, b_ready, out_last and err_oversize are all 0.
- Arbitration latency:
  - A request seen in IDLE at cycle N gets its first possible transfer at cycle N+1.
  - Exactly one idle cycle separates consecutive frames, including back-to-back frames from the same port.
- Data latency through a granted port is 0 cycles. The datapath adds no registers.
- Counters update on the clock edge that ends the completing beat.
- Reset asserted mid-frame aborts the frame; the next cycle is IDLE. The partial frame is not counted.
- A single-word frame (valid & last on the first beat) costs 2 cycles total: 1 in IDLE, 1 in GRANT.

## Configuration
- Macro: ETH_ARB_FRAME_LIMIT_EN.
- **Defined:**
  - A CNT_W word counter clears on grant and increments on each beat.
  - On the MAX_WORDS-th beat, if x_last = 0:
    - out_last is forced to 1.
    - err_oversize pulses for that cycle.
    - frames_x increments and `prio` flips.
    - Next state is DROP_x.
  - In DROP_x:
    - x_ready = 1 and out_valid = 0; incoming words are discarded.
    - On a beat with x_last, go to IDLE.
  - A frame of exactly MAX_WORDS words with last on the final word is not an error.
- **Undefined:**
  - No word counter and no DROP states.
  - err_oversize is tied to 0.
  - Frames of any length pass untouched.

## Test plan
- Reset, then a 4-word frame on A only, with out_ready = 1:
  - out_valid rises 1 cycle after a_valid.
  - Words pass 1:1 and out_last is on word 4.
  - frames_a = 1 and out_src = 0.
- A and B both request at the same cycle after reset, 3-word frames each:
  - A goes first, then 1 idle cycle, then B.
  - A second simultaneous request afterwards goes to A again, since prio returned to A after B.
- Egress backpressure: a 5-word frame on B with out_ready toggled 1,0,1,0:
  - b_ready mirrors out_ready.
  - a_ready stays 0 even with a_valid = 1.
  - No word is lost or duplicated.
- Reset asserted on word 2 of a 6-word A frame:
  - Next cycle is IDLE with all outputs 0.
  - frames_a is unchanged at 0.
- Counter wrap: with CNT_W = 4, send 17 single-word frames on A:
  - frames_a = 1 at the end.
  - The idle cycles between frames are observed.
- With ETH_ARB_FRAME_LIMIT_EN and MAX_WORDS = 8:
  - A 12-word frame gives 8 egress words, out_last on word 8, err_oversize high for 1 cycle, then 4 words silently dropped.
  - An 8-word frame passes with err_oversize = 0.
